// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter that sequences one access at a time into the
// single SRAM controller and returns a done pulse (with err on timeout) to the winner.
module sram_arbiter #(
    parameter int unsigned ADDR_W         = 18,
    parameter int unsigned DATA_W         = 16,
    parameter logic [3:0]  OP_READ        = 4'd10,
    parameter logic [3:0]  OP_WRITE       = 4'd11,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,

    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,

    output logic [3:0]        mem_opcode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    // Per-port request view so the winner can be selected by index.
    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];

    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              winner_q,     winner_d;
    logic              we_q,         we_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [3:0]        mem_opcode_q, mem_opcode_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;
    logic [1:0]        done_q,       done_d;
    logic              err_q,        err_d;
    logic              busy_q,       busy_d;

    logic              pick;
    logic              timeout_hit;
    logic              finish;
    logic              abort;

    // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
    assign pick        = req_vec[1] & (~req_vec[0] | ~last_grant_q);
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        mem_opcode_d = mem_opcode_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        done_d       = 2'b00;
        err_d        = 1'b0;
        finish       = 1'b0;
        abort        = 1'b0;

        case (state_q)
            S_IDLE: begin
                mem_opcode_d = 4'd0;
                if (|req_vec) begin
                    winner_d     = pick;
                    last_grant_d = pick;
                    we_d         = we_vec[pick];
                    mem_addr_d   = addr_vec[pick];
                    mem_wdata_d  = wdata_vec[pick];
                    mem_opcode_d = we_vec[pick] ? OP_WRITE : OP_READ;
                    cnt_d        = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_hit) begin
                    abort = 1'b1;
                end else if (mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A completing controller takes precedence over a coincident timeout.
                cnt_d = cnt_q + CNT_W'(1);
                if (!mem_ready) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            S_RELEASE: begin
                mem_opcode_d = 4'd0;
                state_d      = S_IDLE;
            end
            default: begin
                mem_opcode_d = 4'd0;
                state_d      = S_IDLE;
            end
        endcase

        if (finish || abort) begin
            state_d          = S_RELEASE;
            mem_opcode_d     = 4'd0;
            done_d[winner_q] = 1'b1;
            err_d            = abort;
            if (abort) begin
                rdata_d = '0;
            end else if (!we_q) begin
                rdata_d = mem_rdata;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_opcode_q <= 4'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            done_q       <= 2'b00;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            mem_opcode_q <= mem_opcode_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign done0      = done_q[0];
    assign done1      = done_q[1];
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign mem_opcode = mem_opcode_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
